snax_streamer_vec_add_shell_wrapper: RTL and testbench

Parametrised streamer-facing accelerator shell that does its own CSR-launched job control. It reduces `NumInStreams` lane-parallel input streams into one output stream with a lane-wise add, using either wrapping or signed-saturating arithmetic. The block sits between the SNAX streamer and the CSR manager, in the same slot as the GEMM shell wrappers. It also owns the busy flag, the beat counter, the output pipeline register and the optional cycle counter.

---
 rtl/snax_streamer_vec_add_shell_wrapper.sv | 139 +++++++++++++
 tb/tb_snax_streamer_vec_add_shell_wrapper.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_streamer_vec_add_shell_wrapper.sv
// Lane-wise add of NumInStreams streams into one output stream (wrap or signed-saturate), CSR-launched.
// One-cycle fire-to-valid latency; inputs join and stall together on output backpressure. Option: SNAX_VEC_ADD_PERF_CNT_EN.
module snax_streamer_vec_add_shell_wrapper #(
  parameter int unsigned NumInStreams = 2,
  parameter int unsigned LaneCount    = 8,
  parameter int unsigned ElemWidth    = 32,
  parameter int unsigned DataWidth    = LaneCount * ElemWidth,
  parameter int unsigned RegRWCount   = 2,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumInStreams-1:0][DataWidth-1:0]   stream2acc_data_i,
  input  logic [NumInStreams-1:0]                  stream2acc_valid_i,
  output logic [NumInStreams-1:0]                  stream2acc_ready_o,
  output logic [DataWidth-1:0]                     acc2stream_0_data_o,
  output logic                                     acc2stream_0_valid_o,
  input  logic                                     acc2stream_0_ready_i,
  input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
  input  logic                                     csr_reg_set_valid_i,
  output logic                                     csr_reg_set_ready_o,
  output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o
);

  localparam int unsigned SumWidth = ElemWidth + $clog2(NumInStreams);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             n_q;
  logic [31:0]             beat_cnt_q;
  logic                    mode_q;
  logic                    out_vld_q;
  logic [DataWidth-1:0]    out_dat_q;
  logic [DataWidth-1:0]    sum_dat;
  logic [SumWidth-1:0]     lane_acc;
  logic [ElemWidth-1:0]    lane_elem;
  logic [RegDataWidth-1:0] cyc_cnt;
  logic                    busy;
  logic                    launch;
  logic                    pop;
  logic                    fire;
  logic                    unused_csr_bits;

  assign busy   = (state_q != IDLE);
  assign launch = (state_q == IDLE) && csr_reg_set_valid_i;
  assign pop    = out_vld_q && acc2stream_0_ready_i;
  // The output register may be refilled in the same cycle it is popped.
  assign fire   = (state_q == RUN) && (&stream2acc_valid_i) && (!out_vld_q || pop);

  assign stream2acc_ready_o   = {NumInStreams{fire}};
  assign acc2stream_0_valid_o = out_vld_q;
  assign acc2stream_0_data_o  = out_dat_q;
  assign csr_reg_set_ready_o  = (state_q == IDLE);
  assign unused_csr_bits      = ^csr_reg_set_i[1][RegDataWidth-1:1];

  always_comb begin
    csr_reg_ro_set_o       = '0;
    csr_reg_ro_set_o[0][0] = busy;
    csr_reg_ro_set_o[1]    = cyc_cnt;
  end

  // Saturation: the sum overflows ElemWidth whenever its top bits are not a pure sign extension.
  always_comb begin
    sum_dat   = '0;
    lane_acc  = '0;
    lane_elem = '0;
    for (int i = 0; i < LaneCount; i++) begin
      lane_acc = '0;
      for (int k = 0; k < NumInStreams; k++) begin
        lane_elem = stream2acc_data_i[k][i*ElemWidth +: ElemWidth];
        lane_acc  = lane_acc + {{(SumWidth-ElemWidth){lane_elem[ElemWidth-1]}}, lane_elem};
      end
      if (mode_q && (lane_acc[SumWidth-1:ElemWidth-1] !=
                     {(SumWidth-ElemWidth+1){lane_acc[SumWidth-1]}})) begin
        sum_dat[i*ElemWidth +: ElemWidth] = lane_acc[SumWidth-1] ?
            {1'b1, {(ElemWidth-1){1'b0}}} : {1'b0, {(ElemWidth-1){1'b1}}};
      end else begin
        sum_dat[i*ElemWidth +: ElemWidth] = lane_acc[ElemWidth-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch && (csr_reg_set_i[0][31:0] != 32'd0)) state_d = RUN;
      RUN:     if (fire && (beat_cnt_q == n_q - 32'd1)) state_d = DRAIN;
      DRAIN:   if (pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      n_q        <= '0;
      mode_q     <= 1'b0;
      beat_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        n_q        <= csr_reg_set_i[0][31:0];
        mode_q     <= csr_reg_set_i[1][0];
        beat_cnt_q <= '0;
      end else if (fire) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (fire) begin
        out_vld_q <= 1'b1;
        out_dat_q <= sum_dat;
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
    end
  end

`ifdef SNAX_VEC_ADD_PERF_CNT_EN
  logic [RegDataWidth-1:0] cyc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q <= '0;
    end else if (launch) begin
      cyc_cnt_q <= '0;
    end else if (busy && (cyc_cnt_q != {RegDataWidth{1'b1}})) begin
      cyc_cnt_q <= cyc_cnt_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_snax_streamer_vec_add_shell_wrapper.sv
// Randomized bench for the vec-add shell: lane sums come from plain integer arithmetic per beat index.
module tb_snax_streamer_vec_add_shell_wrapper;

  localparam int NS = 2;
  localparam int LC = 8;
  localparam int EW = 32;
  localparam int DW = LC * EW;

  logic                   clk;
  logic                   rst_n;
  logic [NS-1:0][DW-1:0]  in_dat;
  logic [NS-1:0]          in_vld;
  logic [NS-1:0]          in_rdy;
  logic [DW-1:0]          out_dat;
  logic                   out_vld;
  logic                   out_rdy;
  logic [1:0][31:0]       csr_set;
  logic                   csr_vld;
  logic                   csr_rdy;
  logic [1:0][31:0]       csr_ro;

  int vectors;
  int errors;
  int first_pop_cyc;
  int last_pop_cyc;
  logic [DW-1:0] last_pop_dat;
  logic [DW-1:0] bm [NS][16];

  snax_streamer_vec_add_shell_wrapper dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .stream2acc_data_i    (in_dat),
    .stream2acc_valid_i   (in_vld),
    .stream2acc_ready_o   (in_rdy),
    .acc2stream_0_data_o  (out_dat),
    .acc2stream_0_valid_o (out_vld),
    .acc2stream_0_ready_i (out_rdy),
    .csr_reg_set_i        (csr_set),
    .csr_reg_set_valid_i  (csr_vld),
    .csr_reg_set_ready_o  (csr_rdy),
    .csr_reg_ro_set_o     (csr_ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_beat(input int j, input bit mode);
    logic [DW-1:0] r;
    longint s;
    longint smax;
    longint smin;
    smax = 64'sd2147483647;
    smin = -smax - 1;
    r = '0;
    for (int i = 0; i < LC; i++) begin
      s = 0;
      for (int k = 0; k < NS; k++) s = s + longint'($signed(bm[k][j][i*EW +: EW]));
      if (!mode)          r[i*EW +: EW] = s[31:0];
      else if (s > smax)  r[i*EW +: EW] = 32'h7FFF_FFFF;
      else if (s < smin)  r[i*EW +: EW] = 32'h8000_0000;
      else                r[i*EW +: EW] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_elem();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  task automatic fill_const(input int k, input int nb, input logic [31:0] v);
    for (int j = 0; j < nb; j++)
      for (int i = 0; i < LC; i++) bm[k][j][i*EW +: EW] = v;
  endtask

  task automatic fill_rand(input int nb);
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < nb; j++)
        for (int i = 0; i < LC; i++) bm[k][j][i*EW +: EW] = rnd_elem();
  endtask

  task automatic launch(input int n, input bit mode);
    @(posedge clk); #2;
    csr_set[0] = n;
    csr_set[1] = {31'($urandom_range(0, 1000)), mode};
    csr_vld    = 1'b1;
    in_vld     = '0;
    out_rdy    = 1'b0;
    #2;
    vectors++;
    if (csr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL launch_ready: got %b want 1", csr_rdy);
    end
  endtask

  // Drives one job and checks join, ordering, hold, latency and busy against the beat model.
  task automatic run_job(input int n, input bit mode, input int vld_pct, input int rdy_pct,
                         input int hold_s1, input int stall_first, input bit poke_busy);
    int ptr[NS];
    int pop_idx, cyc, busy_cyc, stall_left, tail;
    bit busy_m, prev_fire, prev_stall, fire, all_v, exp_r;
    logic [DW-1:0] prev_dat;
    logic [DW-1:0] exp;
    logic [31:0]   exp_ro1;
    for (int k = 0; k < NS; k++) ptr[k] = 0;
    pop_idx = 0; cyc = 0; busy_cyc = 0; tail = 0;
    stall_left = stall_first;
    prev_fire = 0; prev_stall = 0; prev_dat = '0;
    first_pop_cyc = -1; last_pop_cyc = -1; last_pop_dat = '0;
    launch(n, mode);
    busy_m = (n != 0);
    while (tail < 2) begin
      @(posedge clk); #2;
      cyc++;
      csr_vld = poke_busy && (cyc == 2);
      if (csr_vld) csr_set[0] = 32'd7;
      for (int k = 0; k < NS; k++) begin
        in_vld[k] = (ptr[k] < n) && ($urandom_range(1, 100) <= vld_pct) && !(k == 1 && cyc <= hold_s1);
        in_dat[k] = (ptr[k] < n) ? bm[k][ptr[k]] : {8{$urandom()}};
      end
      if (out_vld && stall_left > 0 && pop_idx == 0) begin
        out_rdy = 1'b0;
        stall_left--;
      end else begin
        out_rdy = ($urandom_range(1, 100) <= rdy_pct);
      end
      #2;
      all_v = &in_vld;
      exp_r = busy_m && all_v && (!out_vld || out_rdy);
      vectors++;
      if (in_rdy !== {NS{exp_r}}) begin
        errors++;
        $display("FAIL join_ready cyc=%0d: got %b want %b (valid %b)", cyc, in_rdy, {NS{exp_r}}, in_vld);
      end
      fire = in_rdy[0] && all_v;
      if (prev_fire) begin
        vectors++;
        if (out_vld !== 1'b1) begin
          errors++;
          $display("FAIL latency cyc=%0d: out valid %b want 1", cyc, out_vld);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (out_vld !== 1'b1 || out_dat !== prev_dat) begin
          errors++;
          $display("FAIL hold cyc=%0d: valid %b data %h want 1 / %h", cyc, out_vld, out_dat, prev_dat);
        end
      end
      if (out_vld && out_rdy) begin
        vectors++;
        if (pop_idx >= n) begin
          errors++;
          $display("FAIL extra_beat cyc=%0d: beat %0d of %0d data %h", cyc, pop_idx, n, out_dat);
        end else begin
          exp = exp_beat(pop_idx, mode);
          if (out_dat !== exp) begin
            errors++;
            $display("FAIL data beat=%0d mode=%0d: got %h want %h", pop_idx, mode, out_dat, exp);
          end
        end
        if (pop_idx == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        last_pop_dat = out_dat;
        pop_idx++;
      end
      vectors++;
      if (csr_ro[0] !== {31'b0, busy_m} || csr_rdy !== !busy_m) begin
        errors++;
        $display("FAIL busy cyc=%0d: ro0 %h csr_ready %b want busy %b", cyc, csr_ro[0], csr_rdy, busy_m);
      end
      if (busy_m) busy_cyc++;
      prev_fire  = fire;
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      if (fire) for (int k = 0; k < NS; k++) ptr[k]++;
      if (busy_m && pop_idx == n && out_vld && out_rdy) busy_m = 0;
      if (!busy_m) tail++;
      if (cyc > 600) begin
        errors++;
        $display("FAIL timeout: %0d of %0d beats after %0d cycles", pop_idx, n, cyc);
        tail = 2;
      end
    end
    vectors++;
    if (pop_idx != n) begin
      errors++;
      $display("FAIL beat_count: got %0d want %0d", pop_idx, n);
    end
`ifdef SNAX_VEC_ADD_PERF_CNT_EN
    exp_ro1 = 32'(busy_cyc);
`else
    exp_ro1 = 32'd0;
`endif
    vectors++;
    if (csr_ro[1] !== exp_ro1) begin
      errors++;
      $display("FAIL cycle_counter: got %0d want %0d", csr_ro[1], exp_ro1);
    end
    in_vld = '0;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_vld = '1;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (out_vld !== 1'b0 || out_dat !== '0 || in_rdy !== '0 || csr_rdy !== 1'b1 || csr_ro !== '0) begin
      errors++;
      $display("FAIL reset_values: valid %b data %h in_ready %b csr_ready %b ro %h", out_vld, out_dat, in_rdy, csr_rdy, csr_ro);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    in_vld = '0;
    out_rdy = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] want;
    fill_const(0, 4, 32'd5);
    fill_const(1, 4, 32'd7);
    run_job(4, 1'b0, 100, 100, 0, 0, 1'b0);
    want = {LC{32'd12}};
    vectors++;
    if (last_pop_dat !== want || first_pop_cyc != 2 || last_pop_cyc - first_pop_cyc != 3) begin
      errors++;
      $display("FAIL basic_sum: data %h first %0d last %0d want %h first 2 last 5", last_pop_dat, first_pop_cyc, last_pop_cyc, want);
    end
  endtask

  task automatic test_arith();
    logic [31:0] l0;
    fill_const(0, 1, 32'h7FFF_FFFF);
    fill_const(1, 1, 32'h0000_0001);
    run_job(1, 1'b0, 100, 100, 0, 0, 1'b0);
    l0 = last_pop_dat[31:0];
    vectors++;
    if (l0 !== 32'h8000_0000) begin
      errors++;
      $display("FAIL wrap_overflow: got %h want 80000000", l0);
    end
    run_job(1, 1'b1, 100, 100, 0, 0, 1'b0);
    l0 = last_pop_dat[31:0];
    vectors++;
    if (l0 !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL sat_positive: got %h want 7fffffff", l0);
    end
    fill_const(0, 1, 32'h8000_0000);
    fill_const(1, 1, 32'hFFFF_FFFF);
    run_job(1, 1'b1, 100, 100, 0, 0, 1'b0);
    l0 = last_pop_dat[31:0];
    vectors++;
    if (l0 !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sat_negative: got %h want 80000000", l0);
    end
  endtask

  task automatic test_withhold();
    fill_rand(3);
    run_job(3, 1'b0, 100, 100, 2, 0, 1'b0);
    vectors++;
    if (first_pop_cyc != 4) begin
      errors++;
      $display("FAIL withhold_first_beat: popped at cycle %0d want 4", first_pop_cyc);
    end
  endtask

  task automatic test_back_to_back();
    fill_rand(2);
    run_job(2, 1'($urandom_range(0, 1)), 100, 100, 0, 3, 1'b1);
    vectors++;
    if (first_pop_cyc != 5 || last_pop_cyc != 6) begin
      errors++;
      $display("FAIL backpressure_timing: pops at %0d,%0d want 5,6", first_pop_cyc, last_pop_cyc);
    end
  endtask

  task automatic test_zero_len();
    launch(0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      csr_vld = 1'b0;
      in_vld  = '1;
      in_dat  = {NS{{8{$urandom()}}}};
      out_rdy = 1'b1;
      #2;
      vectors++;
      if (in_rdy !== '0 || out_vld !== 1'b0 || csr_ro[0] !== 32'd0 || csr_rdy !== 1'b1) begin
        errors++;
        $display("FAIL zero_len cyc=%0d: in_ready %b valid %b ro0 %h csr_ready %b", c, in_rdy, out_vld, csr_ro[0], csr_rdy);
      end
    end
    in_vld = '0;
    out_rdy = 1'b0;
  endtask

  task automatic test_random();
    int n;
    bit m;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      m = 1'($urandom_range(0, 1));
      fill_rand(n);
      run_job(n, m, 75, 65, 0, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_job();
    int pops;
    int c;
    fill_rand(5);
    launch(5, 1'b0);
    pops = 0;
    c = 0;
    while (pops < 2 && c < 40) begin
      @(posedge clk); #2;
      csr_vld = 1'b0;
      for (int k = 0; k < NS; k++) in_dat[k] = bm[k][0];
      in_vld  = '1;
      out_rdy = 1'b1;
      #2;
      if (out_vld) pops++;
      c++;
    end
    vectors++;
    if (pops != 2) begin
      errors++;
      $display("FAIL mid_reset_setup: %0d pops want 2", pops);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_vld !== 1'b0 || csr_ro[0] !== 32'd0 || csr_ro[1] !== 32'd0 || csr_rdy !== 1'b1 || in_rdy !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid %b ro0 %h ro1 %h csr_ready %b in_ready %b", out_vld, csr_ro[0], csr_ro[1], csr_rdy, in_rdy);
    end
    in_vld = '0;
    out_rdy = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    fill_rand(1);
    run_job(1, 1'b1, 100, 100, 0, 0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    in_dat  = '0;
    in_vld  = '0;
    out_rdy = 1'b0;
    csr_set = '0;
    csr_vld = 1'b0;
    test_reset();
    test_basic();
    test_arith();
    test_withhold();
    test_back_to_back();
    test_zero_len();
    test_random();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
